// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with x0 hardwired to zero, a post-reset clear sweep and optional write forwarding.
// Define RF_TRACE_EN to print a trace line for every committed write.
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int NR    = 2,
  parameter int FWD   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NR*AW-1:0]       ra,
  output logic [NR*XLEN-1:0]     rd,
  input  logic                   we0,
  input  logic [AW-1:0]          wa0,
  input  logic [XLEN-1:0]        wd0,
  input  logic                   we1,
  input  logic [AW-1:0]          wa1,
  input  logic [XLEN-1:0]        wd1,
  input  logic [`ADDR_SIZE-1:0]  pc,
  output logic                   busy
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic [XLEN-1:0] rf_q [DEPTH];
  logic last, sweep, w0, w1;
  assign last  = clr_idx_q == AW'(DEPTH - 1);
  assign sweep = state_q == CLEAR && !reset;
  assign busy  = reset || state_q == CLEAR;
  assign w0    = !busy && we0 && wa0 != '0;
  assign w1    = !busy && we1 && wa1 != '0;
  always_comb begin
    state_d   = (state_q == CLEAR && last) ? RUN : state_q;
    clr_idx_d = (state_q == CLEAR) ? clr_idx_q + 1'b1 : clr_idx_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_idx_q <= AW'(1);
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end
  // Port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (sweep) rf_q[clr_idx_q] <= '0;
    else begin
      if (w0) rf_q[wa0] <= wd0;
      if (w1) rf_q[wa1] <= wd1;
    end
  end
  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [AW-1:0] a;
    assign a = ra[i*AW +: AW];
    assign rd[i*XLEN +: XLEN] = (busy || a == '0) ? '0 :
                                (FWD != 0 && we1 && wa1 == a) ? wd1 :
                                (FWD != 0 && we0 && wa0 == a) ? wd0 : rf_q[a];
  end
`ifdef RF_TRACE_EN
  always_ff @(posedge clk) begin
    if (w0 && !(w1 && wa1 == wa0)) $display("pc = %h: x%d = %h", pc, wa0, wd0);
    if (w1) $display("pc = %h: x%d = %h", pc, wa1, wd1);
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc;
`endif
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of clear sweep, writes, collisions, forwarding and reset restart.
// Two instances share all inputs: dut_f forwards (FWD=1), dut_n does not (FWD=0).
module tb_regfile_mp;
  logic clk = 0, reset = 1;
  logic [9:0] ra = '0;
  logic [63:0] rd_f, rd_n;
  logic we0 = 0, we1 = 0, busy_f, busy_n;
  logic [4:0] wa0 = '0, wa1 = '0;
  logic [31:0] wd0 = '0, wd1 = '0;
  logic [31:0] pc = 32'h1000;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  regfile_mp #(.FWD(1)) dut_f (.clk(clk), .reset(reset), .ra(ra), .rd(rd_f), .we0(we0), .wa0(wa0),
    .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1), .pc(pc), .busy(busy_f));
  regfile_mp #(.FWD(0)) dut_n (.clk(clk), .reset(reset), .ra(ra), .rd(rd_n), .we0(we0), .wa0(wa0),
    .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1), .pc(pc), .busy(busy_n));

  task automatic tick();
    @(posedge clk);
    #1;
    pc = pc + 4;
  endtask

  task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1);
    ra = {a1, a0};
    #1;
  endtask

  task automatic test_reset();
    reset = 1;
    tick();
    tick();
    n_cmp++;
    if (busy_f !== 1'b1) begin n_bad++; $display("FAIL reset_busy got %b want 1", busy_f); end
    reset = 0;
    we0 = 1; wa0 = 5'd4; wd0 = 32'hFF;
    set_ra(5'd4, 5'd0);
    n_cmp++;
    if (rd_f[31:0] !== 32'h0) begin n_bad++; $display("FAIL busy_read got %h want 0", rd_f[31:0]); end
    for (int e = 1; e <= 31; e++) begin
      tick();
      n_cmp++;
      if (busy_f !== (e < 31) || busy_n !== (e < 31)) begin
        n_bad++; $display("FAIL sweep_busy edge %0d got %b/%b want %b", e, busy_f, busy_n, e < 31);
      end
    end
    we0 = 0;
    for (int r = 1; r < 32; r++) begin
      set_ra(5'(r), 5'(r));
      n_cmp++;
      if (rd_f !== 64'h0 || rd_n !== 64'h0) begin
        n_bad++; $display("FAIL cleared x%0d got %h/%h want 0", r, rd_f, rd_n);
      end
    end
  endtask

  task automatic test_basic();
    we0 = 1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
    set_ra(5'd5, 5'd0);
    n_cmp++;
    if (rd_f[31:0] !== 32'hDEADBEEF || rd_n[31:0] !== 32'h0) begin
      n_bad++; $display("FAIL basic_same_cycle got %h/%h want deadbeef/0", rd_f[31:0], rd_n[31:0]);
    end
    tick();
    we0 = 0;
    #1;
    n_cmp++;
    if (rd_f[31:0] !== 32'hDEADBEEF || rd_n[31:0] !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL basic_x5 got %h/%h want deadbeef", rd_f[31:0], rd_n[31:0]);
    end
    we0 = 1; wa0 = 5'd0; wd0 = 32'h1234;
    set_ra(5'd0, 5'd0);
    n_cmp++;
    if (rd_f !== 64'h0 || rd_n !== 64'h0) begin n_bad++; $display("FAIL x0_fwd got %h/%h want 0", rd_f, rd_n); end
    tick();
    we0 = 0;
    #1;
    n_cmp++;
    if (rd_f !== 64'h0 || rd_n !== 64'h0) begin n_bad++; $display("FAIL x0_stored got %h/%h want 0", rd_f, rd_n); end
  endtask

  task automatic test_collision();
    we0 = 1; we1 = 1; wa0 = 5'd7; wa1 = 5'd7; wd0 = 32'h11111111; wd1 = 32'h22222222;
    set_ra(5'd7, 5'd7);
    n_cmp++;
    if (rd_f !== {2{32'h22222222}}) begin n_bad++; $display("FAIL coll_fwd got %h want 22222222 x2", rd_f); end
    tick();
    we0 = 0; we1 = 0;
    #1;
    n_cmp++;
    if (rd_f[31:0] !== 32'h22222222 || rd_n[31:0] !== 32'h22222222) begin
      n_bad++; $display("FAIL coll_x7 got %h/%h want 22222222", rd_f[31:0], rd_n[31:0]);
    end
    we0 = 1; we1 = 1; wa0 = 5'd8; wa1 = 5'd9; wd0 = 32'h88888888; wd1 = 32'h99999999;
    tick();
    we0 = 0; we1 = 0;
    set_ra(5'd8, 5'd9);
    n_cmp++;
    if (rd_f !== {32'h99999999, 32'h88888888} || rd_n !== {32'h99999999, 32'h88888888}) begin
      n_bad++; $display("FAIL dual_x8_x9 got %h/%h want 9999999988888888", rd_f, rd_n);
    end
  endtask

  task automatic test_forward();
    we0 = 1; wa0 = 5'd3; wd0 = 32'h33333333;
    tick();
    we0 = 1; wa0 = 5'd3; wd0 = 32'h5A5A5A5A;
    we1 = 1; wa1 = 5'd3; wd1 = 32'hA5A5A5A5;
    set_ra(5'd3, 5'd3);
    n_cmp++;
    if (rd_f !== {2{32'hA5A5A5A5}}) begin n_bad++; $display("FAIL fwd_on got %h want a5a5a5a5 x2", rd_f); end
    n_cmp++;
    if (rd_n !== {2{32'h33333333}}) begin n_bad++; $display("FAIL fwd_off got %h want 33333333 x2", rd_n); end
    we0 = 0;
    #1;
    n_cmp++;
    if (rd_f !== {2{32'hA5A5A5A5}}) begin n_bad++; $display("FAIL fwd_we1_only got %h want a5a5a5a5 x2", rd_f); end
    we1 = 0; we0 = 1; wd0 = 32'h0F0F0F0F;
    #1;
    n_cmp++;
    if (rd_f[31:0] !== 32'h0F0F0F0F || rd_n[31:0] !== 32'h33333333) begin
      n_bad++; $display("FAIL fwd_we0 got %h/%h want 0f0f0f0f/33333333", rd_f[31:0], rd_n[31:0]);
    end
    we0 = 0;
    #1;
  endtask

  task automatic test_mid_clear();
    we0 = 1; wa0 = 5'd20; wd0 = 32'h55;
    tick();
    we0 = 0;
    set_ra(5'd20, 5'd5);
    n_cmp++;
    if (rd_f !== {32'hDEADBEEF, 32'h55}) begin n_bad++; $display("FAIL pre_x20 got %h want deadbeef00000055", rd_f); end
    reset = 1;
    tick();
    reset = 0;
    for (int e = 0; e < 9; e++) tick();
    we1 = 1; wa1 = 5'd6; wd1 = 32'h66;
    set_ra(5'd6, 5'd20);
    n_cmp++;
    if (rd_f !== 64'h0) begin n_bad++; $display("FAIL busy_no_fwd got %h want 0", rd_f); end
    reset = 1;
    tick();
    n_cmp++;
    if (busy_f !== 1'b1) begin n_bad++; $display("FAIL mid_reset_busy got %b want 1", busy_f); end
    reset = 0;
    for (int e = 1; e <= 31; e++) begin
      tick();
      n_cmp++;
      if (busy_f !== (e < 31)) begin n_bad++; $display("FAIL restart_busy edge %0d got %b want %b", e, busy_f, e < 31); end
    end
    we1 = 0;
    set_ra(5'd20, 5'd5);
    n_cmp++;
    if (rd_f !== 64'h0 || rd_n !== 64'h0) begin n_bad++; $display("FAIL restart_x20_x5 got %h/%h want 0", rd_f, rd_n); end
    set_ra(5'd6, 5'd31);
    n_cmp++;
    if (rd_f !== 64'h0 || rd_n !== 64'h0) begin n_bad++; $display("FAIL restart_x6_x31 got %h/%h want 0", rd_f, rd_n); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_collision();
    test_forward();
    test_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
